// File: rtl/sram_march_ctrl_if.sv
// sram_march_ctrl_if
// Bundles the BIST control handshake and the SRAM macro bus of
// sram_march_ctrl.
//   slave  modport : the BIST sequencer itself
//   master modport : the requester / SRAM side (testbench, top-level glue)
// Handshake: start is a one-cycle request sampled only while the sequencer
// is idle; busy is high for the whole run and done pulses once as busy falls.
// There is no back-pressure: a request made while busy is simply dropped.
interface sram_march_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRAMS  = 12
);
  logic                  start;
  logic [3:0]            sram_sel;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  busy;
  logic                  done;
  logic [NUM_SRAMS-1:0]  mismatch;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [NUM_SRAMS-1:0]  sram_csb;
  logic                  sram_web;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport slave (
    input  start, sram_sel, pattern, sram_dout,
    output busy, done, mismatch, fail_addr,
           sram_csb, sram_web, sram_addr, sram_din
  );

  modport master (
    output start, sram_sel, pattern, sram_dout,
    input  busy, done, mismatch, fail_addr,
           sram_csb, sram_web, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_march_ctrl.sv
// sram_march_ctrl
// March C- style BIST sequencer for one selected OpenRAM macro: ascending
// write of the pattern, ascending read/invert-write, descending read-back.
// Every read is compared one cycle after it is issued; a mismatch sets a
// sticky per-macro flag and the first failing address of the run is kept.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : sram_march_ctrl_if.slave (start/sram_sel/pattern request,
//               busy/done/mismatch/fail_addr status, SRAM csb/web/addr/din
//               outputs, sram_dout read data)
//   dbg_state : current FSM state encoding
// Optional feature macro: BIST_STOP_ON_FAIL_EN -- when defined, the first
// mismatch ends the run straight away (jump to DONE, no further accesses).
module sram_march_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRAMS  = 12
) (
  input  logic              clk,
  input  logic              reset,
  sram_march_ctrl_if.slave  bus,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_R0, S_W1, S_R1, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam int unsigned           NUM_U    = NUM_SRAMS;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;

  // Pending-compare pipeline: a read issued this cycle is checked next cycle.
  logic                  chk_valid_q;
  logic [ADDR_WIDTH-1:0] chk_addr_q;
  logic [DATA_WIDTH-1:0] chk_exp_q;
  logic                  fail_seen_q;

  logic                  accept;
  logic                  cmp_fail;
  logic                  abort;
  logic                  access_d;
  logic [NUM_SRAMS-1:0]  sel_mask_d;
  logic [NUM_SRAMS-1:0]  sel_mask_q;
  logic [NUM_SRAMS-1:0]  sel_mask_in;

  assign accept   = (state_q == S_IDLE) && bus.start && (32'(bus.sram_sel) < NUM_U);
  assign cmp_fail = chk_valid_q && (bus.sram_dout != chk_exp_q);

`ifdef BIST_STOP_ON_FAIL_EN
  assign abort = cmp_fail;
`else
  assign abort = 1'b0;
`endif

  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    pat_d   = pat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_W0;
          addr_d  = '0;
          sel_d   = bus.sram_sel;
          pat_d   = bus.pattern;
        end
      end
      S_W0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_R0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_R0: state_d = S_W1;
      S_W1: begin
        // At the top address the descending pass starts from the same address.
        if (addr_q == ADDR_MAX) begin
          state_d = S_R1;
        end else begin
          state_d = S_R0;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_R1: begin
        if (addr_q == '0) state_d = S_DRAIN;
        else              addr_d  = addr_q - 1'b1;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_DONE;
  end

  assign access_d    = (state_d == S_W0) || (state_d == S_R0) ||
                       (state_d == S_W1) || (state_d == S_R1);
  assign sel_mask_d  = NUM_SRAMS'(1) << sel_d;
  assign sel_mask_q  = NUM_SRAMS'(1) << sel_q;
  assign sel_mask_in = NUM_SRAMS'(1) << bus.sram_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      sel_q       <= '0;
      pat_q       <= '0;
      chk_valid_q <= 1'b0;
      chk_addr_q  <= '0;
      chk_exp_q   <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      pat_q       <= pat_d;
      chk_valid_q <= ((state_q == S_R0) || (state_q == S_R1)) && !abort;
      chk_addr_q  <= addr_q;
      chk_exp_q   <= (state_q == S_R0) ? pat_q : ~pat_q;
      if (accept)                        fail_seen_q <= 1'b0;
      else if (cmp_fail)                 fail_seen_q <= 1'b1;
    end
  end

  // SRAM and status outputs are registered from next-state values so the
  // macro pins change exactly at the clock edge that enters each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sram_csb  <= '1;
      bus.sram_web  <= 1'b1;
      bus.sram_addr <= '0;
      bus.sram_din  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mismatch  <= '0;
      bus.fail_addr <= '0;
    end else begin
      bus.sram_csb  <= access_d ? ~sel_mask_d : '1;
      bus.sram_web  <= !((state_d == S_W0) || (state_d == S_W1));
      bus.sram_addr <= access_d ? addr_d : '0;
      bus.sram_din  <= (state_d == S_W0) ? pat_d :
                       (state_d == S_W1) ? ~pat_d : '0;
      bus.busy      <= access_d || (state_d == S_DRAIN);
      bus.done      <= (state_d == S_DONE);
      if (accept) begin
        bus.mismatch  <= bus.mismatch & ~sel_mask_in;
        bus.fail_addr <= '0;
      end else if (cmp_fail) begin
        bus.mismatch <= bus.mismatch | sel_mask_q;
        if (!fail_seen_q) bus.fail_addr <= chk_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_ctrl.sv
// tb_sram_march_ctrl
// Directed bench for sram_march_ctrl with a behavioural single-port SRAM
// (one-cycle read latency) and an optional stuck-at-0 fault on bit 0 of
// address 0x40.
module tb_sram_march_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 12;
  localparam int BUDGET = 1100;
`ifdef BIST_STOP_ON_FAIL_EN
  localparam int STUCK_DONE_CYC = 387;
`else
  localparam int STUCK_DONE_CYC = 1026;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  sram_march_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SRAMS(NS)) sif ();

  sram_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SRAMS(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (sif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [2**AW];
  logic          fault_on = 1'b0;

  always @(posedge clk) begin
    if (sif.sram_csb != '1) begin
      if (!sif.sram_web) mem[sif.sram_addr] <= sif.sram_din;
      else sif.sram_dout <= mem[sif.sram_addr] &
                            ~((fault_on && sif.sram_addr == 8'h40) ? 32'h1 : 32'h0);
    end
  end

  // ---------------- bus monitor (counters only written here) ----------------
  int       exp_sel = 0;
  int       csb_bad_cnt = 0;
  int       csb3_low_cnt = 0;
  int       busy_cnt = 0;
  int       done_cnt = 0;
  logic [NS-1:0] sel_mask;

  always @(negedge clk) begin
    sel_mask = NS'(1) << exp_sel;
    if (sif.sram_csb != '1 && sif.sram_csb != ~sel_mask) csb_bad_cnt++;
    if (!sif.sram_csb[3]) csb3_low_cnt++;
    if (sif.busy) busy_cnt++;
    if (sif.done) done_cnt++;
  end

  // ---------------- scoreboard counters ----------------
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Raises start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic pulse_start(input logic [3:0] sel, input logic [DW-1:0] pat);
    @(negedge clk);
    sif.sram_sel = sel;
    sif.pattern  = pat;
    sif.start    = 1'b1;
    @(negedge clk);
    sif.start    = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!sif.done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_cycles(input int c0, input int target, output int cyc);
    cyc = c0;
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input logic [3:0] sel, input logic [DW-1:0] pat, output int cyc);
    pulse_start(sel, pat);
    wait_done(1, cyc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int bad_words;
    int csb_bad0, csb3_0, busy0, done0;

    sif.start     = 1'b0;
    sif.sram_sel  = '0;
    sif.pattern   = '0;
    sif.sram_dout = '0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_csb",       64'(sif.sram_csb),  64'hFFF);
    check("reset_web",       64'(sif.sram_web),  64'h1);
    check("reset_addr",      64'(sif.sram_addr), 64'h0);
    check("reset_din",       64'(sif.sram_din),  64'h0);
    check("reset_busy",      64'(sif.busy),      64'h0);
    check("reset_done",      64'(sif.done),      64'h0);
    check("reset_mismatch",  64'(sif.mismatch),  64'h0);
    check("reset_fail_addr", 64'(sif.fail_addr), 64'h0);

    // Clean run on macro 3.
    exp_sel = 3; csb_bad0 = csb_bad_cnt; csb3_0 = csb3_low_cnt;
    pulse_start(4'd3, 32'hA5A5A5A5);
    check("clean_busy_rise", 64'(sif.busy), 64'h1);
    wait_done(1, cyc);
    check("clean_done_cycle", 64'(cyc), 64'd1026);
    check("clean_busy_at_done", 64'(sif.busy), 64'h0);
    check("clean_mismatch", 64'(sif.mismatch), 64'h0);
    check("clean_csb_only3", 64'(csb_bad_cnt - csb_bad0), 64'h0);
    check("clean_csb3_used", 64'(csb3_low_cnt - csb3_0 > 0), 64'h1);
    bad_words = 0;
    for (int a = 0; a < 2**AW; a++) if (mem[a] !== 32'h5A5A5A5A) bad_words++;
    check("clean_final_contents", 64'(bad_words), 64'h0);
    @(negedge clk);
    check("clean_done_one_cycle", 64'(sif.done), 64'h0);
    check("clean_csb_idle", 64'(sif.sram_csb), 64'hFFF);

    // Illegal select: ignored completely.
    exp_sel = 15; csb_bad0 = csb_bad_cnt; busy0 = busy_cnt; done0 = done_cnt;
    run(4'd12, 32'h12345678, cyc);
    check("illegal_no_busy", 64'(busy_cnt - busy0), 64'h0);
    check("illegal_no_done", 64'(done_cnt - done0), 64'h0);
    check("illegal_csb_high", 64'(csb_bad_cnt - csb_bad0), 64'h0);

    // Stuck-at-0 on bit 0 of address 0x40.
    fault_on = 1'b1; exp_sel = 5;
    run(4'd5, 32'hFFFFFFFF, cyc);
    check("stuck_done_cycle", 64'(cyc), 64'(STUCK_DONE_CYC));
    check("stuck_mismatch", 64'(sif.mismatch), 64'h020);
    check("stuck_fail_addr", 64'(sif.fail_addr), 64'h40);
    fault_on = 1'b0;
    @(negedge clk);

    // Start while busy (mid-W1) with sel=7 must be ignored.
    exp_sel = 6; csb_bad0 = csb_bad_cnt;
    pulse_start(4'd6, 32'h0F0F0F0F);
    wait_cycles(1, 300, cyc);
    sif.sram_sel = 4'd7;
    sif.start    = 1'b1;
    @(negedge clk);
    cyc++;
    sif.start    = 1'b0;
    wait_done(cyc, cyc);
    check("busy_start_done_cycle", 64'(cyc), 64'd1026);
    check("busy_start_csb_sel6", 64'(csb_bad_cnt - csb_bad0), 64'h0);
    check("busy_start_mismatch", 64'(sif.mismatch), 64'h020);
    @(negedge clk);

    // Reset in the middle of R1.
    exp_sel = 1;
    pulse_start(4'd1, 32'h3C3C3C3C);
    wait_cycles(1, 900, cyc);
    reset = 1'b1;
    #1;
    check("midreset_csb_immediate", 64'(sif.sram_csb), 64'hFFF);
    check("midreset_web", 64'(sif.sram_web), 64'h1);
    check("midreset_busy", 64'(sif.busy), 64'h0);
    check("midreset_mismatch", 64'(sif.mismatch), 64'h0);
    check("midreset_addr", 64'(sif.sram_addr), 64'h0);
    check("midreset_din", 64'(sif.sram_din), 64'h0);
    check("midreset_state", 64'(dbg_state), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    run(4'd1, 32'h3C3C3C3C, cyc);
    check("postreset_done_cycle", 64'(cyc), 64'd1026);
    check("postreset_mismatch", 64'(sif.mismatch), 64'h0);
    @(negedge clk);

    // Sticky flags across runs.
    fault_on = 1'b1; exp_sel = 2;
    run(4'd2, 32'hFFFFFFFF, cyc);
    check("sticky_fail_sel2", 64'(sif.mismatch), 64'h004);
    check("sticky_fail_addr", 64'(sif.fail_addr), 64'h40);
    fault_on = 1'b0; exp_sel = 4;
    @(negedge clk);
    run(4'd4, 32'h00000001, cyc);
    check("sticky_after_sel4", 64'(sif.mismatch), 64'h004);
    check("sticky_sel4_fail_addr", 64'(sif.fail_addr), 64'h0);
    exp_sel = 2;
    @(negedge clk);
    run(4'd2, 32'h80000001, cyc);
    check("sticky_cleared_sel2", 64'(sif.mismatch), 64'h000);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
